amount_entry: RTL

//  Consumes the keypad decoder's level outputs (key_value, press_num, start, clear, confirm).

---
 rtl/amount_pkg.sv | 18 +
 rtl/key_edge_sync.sv | 31 +++
 rtl/amount_entry.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/amount_pkg.sv
// amount_pkg: shared definitions for the amount entry block.
//   state_e           FSM state encoding (2 bits)
//   DigitW            BCD digit width
//   DefaultMaxAmount  default largest accepted amount
//   BinW              width of the binary amount (0..99)
package amount_pkg;

  localparam int unsigned DigitW           = 4;
  localparam int unsigned BinW             = 7;
  localparam int unsigned DefaultMaxAmount = 20;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StEntry  = 2'd1,
    StLocked = 2'd2
  } state_e;

endpackage

// File: rtl/key_edge_sync.sv
// key_edge_sync: 2-FF synchroniser followed by a rising-edge detector for one key level.
// Ports:
//   clk    in  system clock
//   rst_n  in  synchronous reset, active-high
//   din    in  asynchronous level from the keypad scanner
//   pulse  out one-cycle pulse when the synchronised level rises
module key_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // A held level produces one pulse only; it must fall before it can fire again.
  assign pulse = s2_q & ~s3_q;

endmodule

// File: rtl/amount_entry.sv
// amount_entry: assembles a 2-digit BCD charge amount from keypad events, validates it
// against MAX_AMOUNT and hands a locked amount plus a ready pulse to the charge controller.
// Ports:
//   clk           in   system clock
//   rst_n         in   synchronous reset, active-high
//   key_value     in   digit 0..9, valid while press_num is high
//   press_num     in   level, digit key held
//   start         in   level, START held
//   clear         in   level, CLEAR held
//   confirm       in   level, CONFIRM held
//   amount_tens   out  BCD tens digit
//   amount_ones   out  BCD ones digit
//   amount_bin    out  binary amount tens*10+ones
//   entry_active  out  FSM in ENTRY
//   amount_locked out  FSM in LOCKED
//   amount_ready  out  one-cycle pulse on ENTRY->LOCKED
//   over_limit    out  last confirm rejected (cleared by digit/clear/start)
//   timeout       out  one-cycle pulse when ENTRY is abandoned for inactivity
module amount_entry
  import amount_pkg::*;
#(
  parameter int unsigned MAX_AMOUNT  = DefaultMaxAmount,
  parameter int unsigned TIMEOUT_CYC = 500_000_000,
  parameter int unsigned TMO_W       = 29
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DigitW-1:0] key_value,
  input  logic              press_num,
  input  logic              start,
  input  logic              clear,
  input  logic              confirm,
  output logic [DigitW-1:0] amount_tens,
  output logic [DigitW-1:0] amount_ones,
  output logic [BinW-1:0]   amount_bin,
  output logic              entry_active,
  output logic              amount_locked,
  output logic              amount_ready,
  output logic              over_limit,
  output logic              timeout
);

  localparam logic [BinW-1:0]  MaxBin  = BinW'(MAX_AMOUNT);
  localparam logic [TMO_W-1:0] TmoLast = TMO_W'(TIMEOUT_CYC - 1);

  // Input synchronisation and event generation
  logic num_ev, start_ev, clear_ev, confirm_ev;
  logic [DigitW-1:0] kv1_q, kv2_q;

  key_edge_sync u_sync_num (.clk(clk), .rst_n(rst_n), .din(press_num), .pulse(num_ev));
  key_edge_sync u_sync_start (.clk(clk), .rst_n(rst_n), .din(start), .pulse(start_ev));
  key_edge_sync u_sync_clear (.clk(clk), .rst_n(rst_n), .din(clear), .pulse(clear_ev));
  key_edge_sync u_sync_confirm (.clk(clk), .rst_n(rst_n), .din(confirm), .pulse(confirm_ev));

  // key_value is stable while press_num is held, so its own 2-FF copy lines up with num_ev.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      kv1_q <= '0;
      kv2_q <= '0;
    end else begin
      kv1_q <= key_value;
      kv2_q <= kv1_q;
    end
  end

  // State
  state_e            state_q, state_d;
  logic [DigitW-1:0] tens_q, tens_d, ones_q, ones_d;
  logic [BinW-1:0]   bin_q, bin_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              over_q, over_d;
  logic              ready_q, ready_d;
  logic              tmo_ev_q, tmo_ev_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              any_ev;

  assign any_ev = num_ev | start_ev | clear_ev | confirm_ev;

  always_comb begin
    state_d  = state_q;
    tens_d   = tens_q;
    ones_d   = ones_q;
    cnt_d    = cnt_q;
    over_d   = over_q;
    ready_d  = 1'b0;
    tmo_ev_d = 1'b0;
    tmo_d    = tmo_q;

    if (clear_ev) begin
      state_d = StIdle;
      tens_d  = '0;
      ones_d  = '0;
      cnt_d   = '0;
      over_d  = 1'b0;
      tmo_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          tmo_d = '0;
          if (start_ev) begin
            state_d = StEntry;
            tens_d  = '0;
            ones_d  = '0;
            cnt_d   = '0;
            over_d  = 1'b0;
          end
        end
        StEntry: begin
          tmo_d = any_ev ? '0 : tmo_q + 1'b1;
          if (confirm_ev) begin
            if (bin_q == '0) begin
              // empty entry: nothing to confirm
            end else if (bin_q > MaxBin) begin
              over_d = 1'b1;
              tens_d = '0;
              ones_d = '0;
              cnt_d  = '0;
            end else begin
              state_d = StLocked;
              ready_d = 1'b1;
            end
          end else if (start_ev) begin
            tens_d = '0;
            ones_d = '0;
            cnt_d  = '0;
            over_d = 1'b0;
          end else if (num_ev) begin
            over_d = 1'b0;
            if (cnt_q == 2'd0) begin
              // leading zero is suppressed
              if (kv2_q != '0) begin
                ones_d = kv2_q;
                cnt_d  = 2'd1;
              end
            end else if (cnt_q == 2'd1) begin
              tens_d = ones_q;
              ones_d = kv2_q;
              cnt_d  = 2'd2;
            end
          end else if (tmo_q == TmoLast) begin
            state_d  = StIdle;
            tens_d   = '0;
            ones_d   = '0;
            cnt_d    = '0;
            over_d   = 1'b0;
            tmo_d    = '0;
            tmo_ev_d = 1'b1;
          end
        end
        StLocked: begin
          tmo_d = '0;
        end
        default: begin
          state_d = StIdle;
          tens_d  = '0;
          ones_d  = '0;
          cnt_d   = '0;
          over_d  = 1'b0;
          tmo_d   = '0;
        end
      endcase
    end

    // tens*10 + ones as tens*8 + tens*2 + ones
    bin_d = {tens_d, 3'b000} + {2'b00, tens_d, 1'b0} + {3'b000, ones_d};
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= StIdle;
      tens_q   <= '0;
      ones_q   <= '0;
      bin_q    <= '0;
      cnt_q    <= '0;
      over_q   <= 1'b0;
      ready_q  <= 1'b0;
      tmo_ev_q <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
      over_q   <= over_d;
      ready_q  <= ready_d;
      tmo_ev_q <= tmo_ev_d;
      tmo_q    <= tmo_d;
    end
  end

  assign amount_tens   = tens_q;
  assign amount_ones   = ones_q;
  assign amount_bin    = bin_q;
  assign entry_active  = (state_q == StEntry);
  assign amount_locked = (state_q == StLocked);
  assign amount_ready  = ready_q;
  assign over_limit    = over_q;
  assign timeout       = tmo_ev_q;

endmodule
